// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash master: default IO addresses,
// CTRL register bit positions and the shift-engine state encoding.
package spi_flash_pkg;

    localparam logic [15:0] DEF_ADR_DATA = 16'h0400;
    localparam logic [15:0] DEF_ADR_CTRL = 16'h0401;
    localparam logic [3:0]  DEF_DIV      = 4'd1;

    // CTRL register layout: {busy, ovr, 2'b0, div, 7'b0, cs}
    localparam int CTRL_CS     = 0;
    localparam int CTRL_DIV_LO = 8;
    localparam int CTRL_DIV_HI = 11;
    localparam int CTRL_OVR    = 14;
    localparam int CTRL_BUSY   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_flash_master_if.sv
// CPU IO bus as seen by the SPI flash master.
//   io_wr/io_rd : one-cycle strobes from the CPU
//   mem_addr    : IO address
//   dout        : CPU write data
//   io_din_spi  : read data returned to the top-level OR-mux
interface spi_flash_master_if;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din_spi;

    modport master (output io_wr, io_rd, mem_addr, dout, input io_din_spi);
    modport slave  (input io_wr, io_rd, mem_addr, dout, output io_din_spi);
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0, MSB-first byte shifter with programmable SCK half period.
//   start   : load tx_byte and begin a transfer (honoured only when idle)
//   tx_byte : byte to send
//   div     : half period is div+1 clk cycles
//   miso    : serial data in, sampled as sck rises
//   busy    : transfer in progress
//   rx_byte : last completed received byte
//   sck     : serial clock, idles low
//   mosi    : serial data out; holds the final bit after a transfer
module spi_shift_engine
    import spi_flash_pkg::*;
(
    input  logic       clk,
    input  logic       resetq,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [3:0] div,
    input  logic       miso,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    spi_state_t state, state_nxt;
    logic [3:0] cnt;
    logic [2:0] bitcnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       tick;

    // Down counter reloaded with div on every state entry; tick ends the phase.
    assign tick = (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOW;
            ST_LOW:  if (tick)  state_nxt = ST_HIGH;
            ST_HIGH: if (tick)  state_nxt = (bitcnt == 3'd7) ? ST_IDLE : ST_LOW;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cnt     <= 4'd0;
            bitcnt  <= 3'd0;
            tx_sh   <= 8'd0;
            rx_sh   <= 8'd0;
            rx_byte <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sh  <= tx_byte;
                        bitcnt <= 3'd0;
                        cnt    <= div;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        cnt   <= div;
                        rx_sh <= {rx_sh[6:0], miso};
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        cnt <= div;
                        if (bitcnt == 3'd7) begin
                            rx_byte <= rx_sh;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            // No shift after the last bit so mosi keeps bit0.
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sck  = (state == ST_HIGH);
    assign busy = (state != ST_IDLE);
    assign mosi = tx_sh[7];

endmodule

// File: rtl/spi_flash_master.sv
// Byte-wide SPI flash master on the j1 IO bus.
//   clk, resetq : system clock, async active-low reset
//   bus         : CPU IO bus (slave side); DATA and CTRL registers
//   spi_sck     : serial clock
//   spi_mosi    : serial data out
//   spi_miso    : serial data in
//   spi_cs_n    : chip select, driven only by software via CTRL.cs
//   busy        : transfer in progress
module spi_flash_master
    import spi_flash_pkg::*;
#(
    parameter logic [15:0] ADR_DATA    = DEF_ADR_DATA,
    parameter logic [15:0] ADR_CTRL    = DEF_ADR_CTRL,
    parameter logic [3:0]  DEFAULT_DIV = DEF_DIV
) (
    input  logic               clk,
    input  logic               resetq,
    spi_flash_master_if.slave  bus,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               spi_cs_n,
    output logic               busy
);

    logic       cs;
    logic       ovr;
    logic [3:0] div;
    logic [7:0] rx_byte;
    logic       hit_data, hit_ctrl;
    logic       wr_data, wr_ctrl, rd_ctrl;
    logic       start;
    logic [15:0] ctrl_val;
    logic [15:0] rd_val;

    assign hit_data = (bus.mem_addr == ADR_DATA);
    assign hit_ctrl = (bus.mem_addr == ADR_CTRL);
    assign wr_data  = bus.io_wr & hit_data;
    assign wr_ctrl  = bus.io_wr & hit_ctrl;
    assign rd_ctrl  = bus.io_rd & hit_ctrl;
    assign start    = wr_data & ~busy;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cs  <= 1'b0;
            div <= DEFAULT_DIV;
            ovr <= 1'b0;
        end else begin
            if (wr_ctrl && !busy) begin
                cs  <= bus.dout[CTRL_CS];
                div <= bus.dout[CTRL_DIV_HI:CTRL_DIV_LO];
            end
            // A write rejected for being busy beats a status read in the same cycle.
            if ((wr_ctrl || wr_data) && busy) ovr <= 1'b1;
            else if (rd_ctrl)                 ovr <= 1'b0;
        end
    end

    assign spi_cs_n = ~cs;

    spi_shift_engine u_engine (
        .clk     (clk),
        .resetq  (resetq),
        .start   (start),
        .tx_byte (bus.dout[7:0]),
        .div     (div),
        .miso    (spi_miso),
        .busy    (busy),
        .rx_byte (rx_byte),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

    always_comb begin
        ctrl_val = 16'd0;
        ctrl_val[CTRL_BUSY]               = busy;
        ctrl_val[CTRL_OVR]                = ovr;
        ctrl_val[CTRL_DIV_HI:CTRL_DIV_LO] = div;
        ctrl_val[CTRL_CS]                 = cs;
    end

    // Decoded on address alone so it can be OR-ed into the top-level mux.
    always_comb begin
        rd_val = 16'd0;
        if (hit_data)      rd_val = {8'd0, rx_byte};
        else if (hit_ctrl) rd_val = ctrl_val;
    end

    assign bus.io_din_spi = rd_val;

endmodule
